// File: rtl/sramlike_mem_slave_pkg.sv
// Shared definitions for the sram-like bus: size encodings and the byte-lane mask rule
// used by both the responder and the initiator-side bridge.
package sramlike_mem_slave_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Size 3 is treated as a full word; unaligned half/word accesses simply follow this rule.
   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: return 4'b0001 << lo;
         SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/sramlike_resp_queue.sv
// In-order response FIFO: each entry holds its read word and a latency countdown that
// ticks every cycle; the head may be popped once its countdown has reached zero.
module sramlike_resp_queue #(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic [31:0]                push_rdata,
   input  logic                       pop,
   output logic                       head_ready,
   output logic [31:0]                head_rdata,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int NW = PW + 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] CD_INIT = CW'(LATENCY - 1);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [NW-1:0] count_q, count_d;
   logic [31:0]   rdata_q [DEPTH];
   logic [31:0]   rdata_d [DEPTH];
   logic [CW-1:0] cd_q    [DEPTH];
   logic [CW-1:0] cd_d    [DEPTH];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      rdata_d  = rdata_q;
      cd_d     = cd_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (cd_q[i] != '0) cd_d[i] = cd_q[i] - CW'(1);
      end

      if (push) begin
         rdata_d[wr_ptr_q] = push_rdata;
         cd_d[wr_ptr_q]    = CD_INIT;
         wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + NW'(1);
         2'b01:   count_d = count_q - NW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry payloads are only meaningful while counted, so they carry no reset.
   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
      cd_q    <= cd_d;
   end

   assign head_ready = (count_q != '0) && (cd_q[rd_ptr_q] == '0);
   assign head_rdata = rdata_q[rd_ptr_q];
   assign full       = (count_q == NW'(DEPTH));
   assign count      = count_q;

endmodule

// File: rtl/sramlike_mem_slave.sv
// Memory-backed responder for the sram-like bus with fixed-latency in-order responses.
// Optional SRAMLIKE_STALL_EN adds LFSR-driven acceptance and response stalls.
module sramlike_mem_slave
   import sramlike_mem_slave_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int DEPTH     = 4,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int AW = $clog2(MEM_WORDS);

   logic [31:0]            mem [MEM_WORDS];
   logic [AW-1:0]          widx;
   logic [3:0]             wmask;
   logic                   accept;
   logic                   pop;
   logic                   head_ready;
   logic [31:0]            head_rdata;
   logic [31:0]            push_rdata;
   logic                   q_full;
   logic [$clog2(DEPTH):0] q_count;
   logic                   accept_gate;
   logic                   resp_gate;
   logic                   data_ok_q, data_ok_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   addr_hi_unused;

`ifdef SRAMLIKE_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge clk) begin
      if (!rstn) lfsr_q <= 16'hACE1;
      else       lfsr_q <= lfsr_d;
   end

   assign accept_gate = (lfsr_q[1:0] != 2'b00);
   assign resp_gate   = ~(lfsr_q[2] & lfsr_q[3]);
`else
   assign accept_gate = 1'b1;
   assign resp_gate   = 1'b1;
`endif

   // A pop in the same cycle never frees a slot for this cycle's push.
   assign addr_ok = rstn & req & ~q_full & accept_gate;
   assign accept  = req & addr_ok;
   assign widx    = addr[AW+1:2];
   assign wmask   = byte_mask(size, addr[1:0]);

   // The read word is taken before this edge's write lands; writes respond with zero.
   assign push_rdata     = wr ? 32'h0 : mem[widx];
   assign addr_hi_unused = ^{addr[31:AW+2], q_count};

   // NOTE: the memory array is deliberately not reset; contents survive rstn.
   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   sramlike_resp_queue #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) u_queue (
      .clk        (clk),
      .rstn       (rstn),
      .push       (accept),
      .push_rdata (push_rdata),
      .pop        (pop),
      .head_ready (head_ready),
      .head_rdata (head_rdata),
      .full       (q_full),
      .count      (q_count)
   );

   assign pop = head_ready & resp_gate;

   always_comb begin
      data_ok_d = 1'b0;
      rdata_d   = rdata_q;
      if (pop) begin
         data_ok_d = 1'b1;
         rdata_d   = head_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         data_ok_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
      end
   end

   assign data_ok = data_ok_q;
   assign rdata   = rdata_q;

endmodule
